// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy engine: moves len words from src_addr to dst_addr in chunks staged through a BURST-deep buffer.
// Build option DMA_COPY_CSUM_EN adds a rotate-XOR checksum of every written word on csum.
module dma_copy_engine #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32,
    parameter int BURST  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] csum
);
    localparam int BYTES = DATA_W / 8;
    localparam int CW    = $clog2(BURST + 1);
    localparam int IW    = $clog2(BURST);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [CW-1:0]       chunk_q, chunk_d;
    logic [CW-1:0]       req_cnt_q, req_cnt_d;
    logic [CW-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic [CW-1:0]       wr_idx_q, wr_idx_d;
    logic                wr_valid_q, wr_valid_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   buffer_q [BURST];

    logic                rd_fire, rsp_take, rsp_last, wr_fire, wr_last;
    logic [LEN_W-1:0]    rem_left;
    logic [IW-1:0]       nxt_idx;

    function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(BURST)) return CW'(BURST);
        return CW'(r);
    endfunction

    // A read request or write transfers on a rising edge where its valid and ready are both high;
    // valid never waits on ready, and wr_valid/wr_addr/wr_data hold while wr_valid=1 and wr_ready=0.
    assign rd_fire  = (state_q == READ) && (req_cnt_q < chunk_q) && rd_req_ready;
    assign rsp_take = (state_q == READ) && rd_rsp_valid && (rsp_cnt_q < req_cnt_q);
    assign rsp_last = rsp_take && ((rsp_cnt_q + CW'(1)) == chunk_q);
    assign wr_fire  = wr_valid_q && wr_ready;
    assign wr_last  = wr_fire && ((wr_idx_q + CW'(1)) == chunk_q);
    assign rem_left = rem_q - LEN_W'(chunk_q);
    assign nxt_idx  = IW'(wr_idx_q + CW'(1));

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        rem_d      = rem_q;
        chunk_d    = chunk_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        wr_idx_d   = wr_idx_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d = src_addr;
                    wr_addr_d = dst_addr;
                    rem_d     = len;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    chunk_d   = chunk_of(len);
                    state_d   = (len == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (rd_fire) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                    rd_addr_d = rd_addr_q + STEP;
                end
                if (rsp_take) rsp_cnt_d = rsp_cnt_q + CW'(1);
                // A one-word chunk has its only word arriving now, so bypass the buffer.
                if (rsp_last) begin
                    state_d    = WRITE;
                    wr_valid_d = 1'b1;
                    wr_idx_d   = '0;
                    wr_data_d  = (rsp_cnt_q == '0) ? rd_rsp_data : buffer_q[0];
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    wr_addr_d = wr_addr_q + STEP;
                    if (wr_last) begin
                        wr_valid_d = 1'b0;
                        rem_d      = rem_left;
                        req_cnt_d  = '0;
                        rsp_cnt_d  = '0;
                        chunk_d    = chunk_of(rem_left);
                        state_d    = (rem_left == '0) ? FIN : READ;
                    end else begin
                        wr_idx_d  = wr_idx_q + CW'(1);
                        wr_data_d = buffer_q[nxt_idx];
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            wr_idx_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rem_q      <= rem_d;
            chunk_q    <= chunk_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            wr_idx_q   <= wr_idx_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_take) buffer_q[rsp_cnt_q[IW-1:0]] <= rd_rsp_data;
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign rd_req_valid = (state_q == READ) && (req_cnt_q < chunk_q);
    assign rd_req_addr  = rd_addr_q;
    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

`ifdef DMA_COPY_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) csum_d = '0;
        else if (wr_fire) csum_d = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

`ifndef SYNTHESIS
    // Stray read data (nothing outstanding) is dropped by the datapath; flag it here.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        rd_rsp_valid |-> (state_q == READ && rsp_cnt_q < req_cnt_q));
`endif

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Parametrised memory-to-memory copy engine; programmable length, chunked through a local BURST-deep buffer.
- Uses valid/ready memory request ports in place of the fixed-size, simulation-only bulk copy.
- Sits between the host command path and the memory fabric.
- Copies len words from src_addr to dst_addr, then pulses done.

Parameters:
- DATA_W, 64, word width in bits; multiple of 8.
- ADDR_W, 64, byte-address width.
- LEN_W, 32, width of the length field (words).
- BURST, 16, buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; captured on accepted start.
- dst_addr  in  ADDR_W  destination byte address; captured on accepted start.
- len  in  LEN_W  word count; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  read request accepted.
- rd_req_addr  out  ADDR_W  read byte address.
- rd_rsp_valid  in  1  read data valid; responses arrive in request order.
- rd_rsp_data  in  DATA_W  read data.
- wr_valid  out  1  write request valid.
- wr_ready  in  1  write accepted.
- wr_addr  out  ADDR_W  write byte address.
- wr_data  out  DATA_W  write data.
- csum  out  DATA_W  running checksum (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Asserting rst_n low mid-copy aborts immediately. No done pulse. Memory ports drop valid asynchronously.
- States: IDLE, READ, WRITE, FIN.
- IDLE: start=1 captures src, dst and len, then moves to READ. If len=0, it moves to FIN instead and issues no memory traffic. Start outside IDLE is ignored.
- Chunking: chunk = min(BURST, remaining), computed on READ entry.
- READ: present chunk requests one per word. rd_req_addr = src + i*(DATA_W/8). Advance only on rd_req_valid and rd_req_ready both high.
- Responses fill buffer[0..chunk-1] in order, up to chunk outstanding. rd_rsp_valid is always accepted; there is no backpressure.
- READ to WRITE: occurs the cycle after the last response is captured.
- WRITE: wr_data = buffer[j] and wr_addr = dst + j*(DATA_W/8). Advance on wr_valid and wr_ready both high.
- wr_valid, wr_addr and wr_data are registered. They stay stable while wr_valid=1 and wr_ready=0.
- After the last write handshake, src and dst advance by chunk*(DATA_W/8) and remaining decrements by chunk. Next state is READ if remaining > 0, else FIN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. A start in the FIN cycle is ignored.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Words written = len exactly. The final partial chunk (len mod BURST) writes only the remaining words.
- A response arriving when none is outstanding is an error. It is ignored in synthesis and flagged by an assertion in simulation.
- Minimum latency for len=1 with always-ready memory and 1-cycle read latency: done 5 cycles after start.

Optional Feature:
- Macro: DMA_COPY_CSUM_EN.
- Defined: csum clears to 0 on accepted start. Each written word is folded in as csum = {csum[DATA_W-2:0], csum[DATA_W-1]} XOR wr_data on every write handshake. The value holds after done until the next start.
- Undefined: csum tied to 0 and no checksum logic is generated.

Test Plan:
- len=0, src=0x1000, dst=0x2000 -> done 1 cycle after FIN entry; no rd_req_valid or wr_valid ever; busy high exactly 1 cycle.
- len=5, BURST=16, memory always ready, latency 1, src words 0xA0..0xA4 at 0x1000 -> 5 writes at 0x2000..0x2020 step 8 carrying 0xA0..0xA4, in order; one done pulse.
- len=37, BURST=16 -> chunks of 16, 16 and 5. The first write of each chunk follows that chunk's last read response. Destination matches source for all 37 words.
- wr_ready low for 3 cycles mid-chunk -> wr_addr and wr_data held stable; no word lost or duplicated; done delayed exactly 3 cycles.
- Wrap case: src=0xFFFF_FFFF_FFFF_FFF8, len=2 -> reads at 0x...FFF8 then 0x0.
- rst_n low during WRITE of len=20 -> outputs 0 asynchronously; no done pulse. A new start after release with len=3 completes normally.
- DMA_COPY_CSUM_EN defined, len=2, data 0x1 then 0x2 -> csum=0x0000_0000_0000_0000 after done: rotl(0x1) XOR 0x2 = 0x2 XOR 0x2.
